// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - credit-gated sliding-window issue scheduler
// with a LAT-deep result tag pipeline for a convolution datapath.
module conv_window_scheduler #(
  parameter int KERNEL  = 3,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int STRIDE  = 1,
  parameter int LAT     = 1,
  parameter int CREDITS = 4,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cred_ret,
  output logic          calc_en,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          res_valid,
  output logic [RW-1:0] res_row,
  output logic [CW-1:0] res_col,
  output logic          res_last,
  output logic          busy,
  output logic          done
);

  localparam int OUT_W    = (IMG_W - KERNEL) / STRIDE + 1;
  localparam int OUT_H    = (IMG_H - KERNEL) / STRIDE + 1;
  localparam int LAST_COL = (OUT_W - 1) * STRIDE;
  localparam int LAST_ROW = (OUT_H - 1) * STRIDE;
  localparam int CRW      = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [CRW-1:0] credit;
  logic           issue;
  logic           last_col;
  logic           last_win;
  logic           pipe_busy;

  logic           v_pipe [LAT];
  logic           l_pipe [LAT];
  logic [RW-1:0]  r_pipe [LAT];
  logic [CW-1:0]  c_pipe [LAT];

  assign issue    = (state == RUN) && (credit != '0);
  assign last_col = (col == CW'(LAST_COL));
  assign last_win = last_col && (row == RW'(LAST_ROW));

  assign calc_en   = issue;
  assign win_row   = row;
  assign win_col   = col;
  assign res_valid = v_pipe[LAT-1];
  assign res_last  = l_pipe[LAT-1];
  assign res_row   = r_pipe[LAT-1];
  assign res_col   = c_pipe[LAT-1];

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (v_pipe[i]) pipe_busy = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue && last_win) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!pipe_busy) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters are cleared after the final window so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (issue) begin
      if (last_win) begin
        row <= '0;
        col <= '0;
      end else if (last_col) begin
        row <= row + RW'(STRIDE);
        col <= '0;
      end else begin
        col <= col + CW'(STRIDE);
      end
    end
  end

  // A return while full and not issuing is dropped so credit never exceeds CREDITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= CRW'(CREDITS);
    end else if (issue && !cred_ret) begin
      credit <= credit - CRW'(1);
    end else if (!issue && cred_ret && credit != CRW'(CREDITS)) begin
      credit <= credit + CRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        v_pipe[i] <= 1'b0;
        l_pipe[i] <= 1'b0;
        r_pipe[i] <= '0;
        c_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= issue;
      l_pipe[0] <= issue && last_win;
      r_pipe[0] <= issue ? row : '0;
      c_pipe[0] <= issue ? col : '0;
      for (int i = 1; i < LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
        r_pipe[i] <= r_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - self-checking bench for conv_window_scheduler,
// three parameterisations driven one at a time against a window-list model.
module tb_conv_window_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1, start2;
  logic       cr0, cr1, cr2;
  logic       ce0, ce1, ce2;
  logic [2:0] wr0, wc0, wr1, wc1;
  logic [0:0] wr2, wc2;
  logic       rv0, rv1, rv2;
  logic [2:0] rr0, rc0, rr1, rc1;
  logic [0:0] rr2, rc2;
  logic       rl0, rl1, rl2;
  logic       bz0, bz1, bz2;
  logic       dn0, dn1, dn2;

  conv_window_scheduler u0 (
    .clk(clk), .rst(rst), .start(start0), .cred_ret(cr0),
    .calc_en(ce0), .win_row(wr0), .win_col(wc0),
    .res_valid(rv0), .res_row(rr0), .res_col(rc0), .res_last(rl0),
    .busy(bz0), .done(dn0)
  );

  conv_window_scheduler #(.KERNEL(3), .IMG_W(7), .IMG_H(7), .STRIDE(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .cred_ret(cr1),
    .calc_en(ce1), .win_row(wr1), .win_col(wc1),
    .res_valid(rv1), .res_row(rr1), .res_col(rc1), .res_last(rl1),
    .busy(bz1), .done(dn1)
  );

  conv_window_scheduler #(.KERNEL(1), .IMG_W(2), .IMG_H(2), .LAT(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .cred_ret(cr2),
    .calc_en(ce2), .win_row(wr2), .win_col(wc2),
    .res_valid(rv2), .res_row(rr2), .res_col(rc2), .res_last(rl2),
    .busy(bz2), .done(dn2)
  );

  int PK[3] = '{3, 3, 1};
  int PW[3] = '{8, 7, 2};
  int PH[3] = '{8, 7, 2};
  int PS[3] = '{1, 2, 1};
  int PL[3] = '{1, 1, 3};
  int PC[3] = '{4, 4, 4};

  int sel;
  logic [31:0] o_ce, o_wr, o_wc, o_rv, o_rr, o_rc, o_rl, o_busy, o_done;

  always_comb begin
    o_ce = '0; o_wr = '0; o_wc = '0; o_rv = '0; o_rr = '0;
    o_rc = '0; o_rl = '0; o_busy = '0; o_done = '0;
    case (sel)
      0: begin
        o_ce = 32'(ce0); o_wr = 32'(wr0); o_wc = 32'(wc0); o_rv = 32'(rv0);
        o_rr = 32'(rr0); o_rc = 32'(rc0); o_rl = 32'(rl0);
        o_busy = 32'(bz0); o_done = 32'(dn0);
      end
      1: begin
        o_ce = 32'(ce1); o_wr = 32'(wr1); o_wc = 32'(wc1); o_rv = 32'(rv1);
        o_rr = 32'(rr1); o_rc = 32'(rc1); o_rl = 32'(rl1);
        o_busy = 32'(bz1); o_done = 32'(dn1);
      end
      default: begin
        o_ce = 32'(ce2); o_wr = 32'(wr2); o_wc = 32'(wc2); o_rv = 32'(rv2);
        o_rr = 32'(rr2); o_rc = 32'(rc2); o_rl = 32'(rl2);
        o_busy = 32'(bz2); o_done = 32'(dn2);
      end
    endcase
  end

  // Reference model: the frame is an ordered list of windows; results are
  // queued with the cycle they are due.
  int   cyc, n_cmp, n_err;
  int   m_run, m_idx, m_n, m_ow, m_credit, m_done_cyc, m_fiss;
  int   q_due[$], q_r[$], q_c[$], q_l[$];
  bit   chk_on, rand_cred;
  logic rst_v, start_v, cred_v;
  int   abort_at, obs_iss, obs_done_cyc, t0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_fiss = 0; m_done_cyc = -1;
    m_credit = PC[sel];
    m_ow = (PW[sel] - PK[sel]) / PS[sel] + 1;
    m_n  = m_ow * ((PH[sel] - PK[sel]) / PS[sel] + 1);
    q_due.delete(); q_r.delete(); q_c.delete(); q_l.delete();
  endtask

  task automatic step();
    int exp_iss, exp_rv, er, ec;
    bit do_rst, was_done;
    @(negedge clk);
    if (rand_cred) cred_v = ($urandom_range(0, 2) == 0);
    exp_iss = (m_run != 0 && m_idx < m_n && m_credit > 0) ? 1 : 0;
    exp_rv  = (q_due.size() > 0 && q_due[0] == cyc) ? 1 : 0;
    er = (m_idx / m_ow) * PS[sel];
    ec = (m_idx % m_ow) * PS[sel];
    if (chk_on) begin
      chk("calc_en", o_ce, exp_iss);
      chk("busy", o_busy, m_run);
      chk("done", o_done, (cyc == m_done_cyc) ? 1 : 0);
      chk("res_valid", o_rv, exp_rv);
      if (exp_iss != 0) begin
        chk("win_row", o_wr, er);
        chk("win_col", o_wc, ec);
      end
      if (exp_rv != 0) begin
        chk("res_row", o_rr, q_r[0]);
        chk("res_col", o_rc, q_c[0]);
        chk("res_last", o_rl, q_l[0]);
      end else begin
        chk("res_last_idle", o_rl, 0);
      end
    end
    if (o_ce === 32'd1) obs_iss++;
    if (o_done === 32'd1) obs_done_cyc = cyc;
    do_rst = rst_v;
    if (abort_at > 0 && exp_iss != 0 && m_fiss + 1 == abort_at) begin
      do_rst = 1'b1;
      abort_at = 0;
    end
    rst    = do_rst;
    start0 = (sel == 0) && start_v;
    start1 = (sel == 1) && start_v;
    start2 = (sel == 2) && start_v;
    cr0    = (sel == 0) && cred_v;
    cr1    = (sel == 1) && cred_v;
    cr2    = (sel == 2) && cred_v;
    if (do_rst) begin
      model_reset();
    end else begin
      was_done = (cyc == m_done_cyc);
      if (exp_iss != 0) begin
        m_credit--;
        q_due.push_back(cyc + PL[sel]);
        q_r.push_back(er);
        q_c.push_back(ec);
        q_l.push_back((m_idx == m_n - 1) ? 1 : 0);
        if (m_idx == m_n - 1) m_done_cyc = cyc + PL[sel] + 2;
        m_idx++;
        m_fiss++;
      end
      if (cred_v) begin
        if (exp_iss != 0 || m_credit < PC[sel]) m_credit++;
      end
      if (exp_rv != 0) begin
        void'(q_due.pop_front()); void'(q_r.pop_front());
        void'(q_c.pop_front());   void'(q_l.pop_front());
      end
      if (m_run == 0 && !was_done && start_v) begin
        m_run = 1; m_idx = 0; m_fiss = 0;
      end else if (m_run != 0 && cyc + 1 == m_done_cyc) begin
        m_run = 0;
      end
    end
    cyc++;
  endtask

  task automatic run_to_done(input int budget);
    int k;
    k = 0;
    while ((m_run != 0 || cyc <= m_done_cyc) && k < budget) begin
      step();
      k++;
    end
    chk("frame_within_budget", 32'(k < budget), 1);
  endtask

  initial begin
    sel = 0; cyc = 0; n_cmp = 0; n_err = 0;
    chk_on = 0; rand_cred = 0; abort_at = 0;
    rst_v = 1'b1; start_v = 1'b0; cred_v = 1'b0;
    rst = 1'b1; start0 = 0; start1 = 0; start2 = 0; cr0 = 0; cr1 = 0; cr2 = 0;
    obs_iss = 0; obs_done_cyc = -1;
    model_reset();
    step();
    chk_on = 1;
    step();
    rst_v = 1'b0;

    // default frame, credits always returned; a stray start mid-frame
    cred_v = 1'b1; obs_iss = 0; t0 = cyc;
    start_v = 1'b1; step(); start_v = 1'b0;
    repeat (5) step();
    start_v = 1'b1; step(); start_v = 1'b0;
    run_to_done(100);
    chk("full_frame_issues", obs_iss, 36);
    chk("full_frame_done_cycle", obs_done_cyc - t0, 39);

    // returns at full credit while idle are dropped
    cred_v = 1'b0; step();
    cred_v = 1'b1; repeat (3) step();
    cred_v = 1'b0; step();

    // no returns: stall after the credit pool empties, then one return
    obs_iss = 0;
    start_v = 1'b1; step(); start_v = 1'b0;
    repeat (20) step();
    chk("stall_issue_count", obs_iss, 4);
    cred_v = 1'b1; step(); cred_v = 1'b0;
    repeat (10) step();
    chk("one_return_one_issue", obs_iss, 5);
    rand_cred = 1;
    run_to_done(600);
    rand_cred = 0;

    // abort on the tenth issue
    cred_v = 1'b1; abort_at = 10; obs_done_cyc = -1;
    start_v = 1'b1; step(); start_v = 1'b0;
    for (int k = 0; k < 40 && abort_at != 0; k++) step();
    chk("abort_reached", abort_at, 0);
    step();
    chk("abort_win_row", o_wr, 0);
    chk("abort_win_col", o_wc, 0);
    chk("abort_res_row", o_rr, 0);
    chk("abort_res_col", o_rc, 0);
    repeat (30) step();
    chk("abort_no_done", obs_done_cyc, -1);
    start_v = 1'b1; step(); start_v = 1'b0;
    run_to_done(100);

    // 7x7 image, stride 2, random credit returns
    sel = 1; rst_v = 1'b1; step(); rst_v = 1'b0;
    rand_cred = 1; obs_iss = 0;
    start_v = 1'b1; step(); start_v = 1'b0;
    run_to_done(300);
    rand_cred = 0;
    chk("stride2_issues", obs_iss, 9);

    // 1x1 kernel on 2x2 image with three-cycle datapath latency
    sel = 2; rst_v = 1'b1; step(); rst_v = 1'b0;
    cred_v = 1'b1; obs_iss = 0; t0 = cyc;
    start_v = 1'b1; step(); start_v = 1'b0;
    run_to_done(50);
    chk("lat3_issues", obs_iss, 4);
    chk("lat3_done_cycle", obs_done_cyc - t0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
